// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEFAULT_RESET_PC : default address of the first fetch after reset
//   INSTR_W          : instruction word width
//   count_width()    : width of an occupancy counter able to hold 0..depth
package fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Occupancy counters must represent the "full" value, hence the extra bit
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for both the decoded-instruction buffer and the
// in-flight PC queue. Head entry is read straight from registered storage,
// so a pushed entry becomes visible one cycle after the push.
// Ports:
//   clock, reset      : rising-edge clock, async active-low reset
//   flush             : synchronous empty (storage contents left as is)
//   push, push_data   : write one entry; accepted when not full or when
//                       the head is popped in the same cycle
//   pop               : remove head entry (ignored when empty)
//   head_data         : entry at the head
//   full, empty, count: occupancy status
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A full FIFO still takes a push when its head leaves in the same cycle
  always_comb begin
    pop_ok_s  = pop && (count_r != '0);
    push_ok_s = push && ((count_r != CNT_DEPTH) || pop_ok_s);
  end

  // Storage, pointers and occupancy; storage is cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = (count_r == CNT_DEPTH);
  assign empty     = (count_r == '0);
  assign count     = count_r;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol and structural invariants of the fetch stage.
// Ports: clock/reset plus the handshake and FIFO status signals observed.
module fetch_unit_checker (
  input logic clock,
  input logic reset,
  input logic rsp_valid,
  input logic pcq_empty,
  input logic pcq_push,
  input logic pcq_full,
  input logic ifq_push,
  input logic ifq_pop,
  input logic ifq_full
);

  // Memory must never return a response with nothing outstanding
  rsp_without_request: assert property (@(posedge clock) disable iff (!reset)
    !(rsp_valid && pcq_empty));

  // Credit accounting keeps both queues from overflowing
  pcq_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(pcq_push && pcq_full));

  ifq_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(ifq_push && ifq_full && !ifq_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches to a variable
// latency instruction memory, squashes responses made stale by a redirect
// and buffers fetched instructions for decode.
// Ports:
//   clock, reset                        : rising-edge clock, async active-low reset
//   imem_req_valid/ready/addr           : fetch request handshake
//   imem_rsp_valid/data                 : in-order responses, no back-pressure
//   redirect_valid/pc                   : taken branch/jump, restart fetch
//   d_valid/ready, d_instr, d_pc        : instruction stream to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [INSTR_W-1:0] d_instr,
  output logic [XLEN-1:0]    d_pc
);

  localparam int CW = count_width(FIFO_DEPTH);
  localparam int EW = XLEN + INSTR_W;
  localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
  localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~(XLEN'(3));

  logic            run_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [CW-1:0]   drop_r;

  logic [CW-1:0]   inflight_s;
  logic [CW-1:0]   inflight_next_s;
  logic [CW-1:0]   fifo_count_s;
  logic [CW:0]     occupancy_s;
  logic            credit_s;
  logic            accept_s;
  logic            rsp_fire_s;
  logic            keep_rsp_s;
  logic            d_pop_s;
  logic [XLEN-1:0] rsp_pc_s;
  logic [EW-1:0]   head_s;
  logic            pcq_full_s;
  logic            pcq_empty_s;
  logic            ifq_full_s;
  logic            ifq_empty_s;

  // Credit, handshakes and post-update in-flight count. Buffered plus
  // outstanding instructions never exceed the buffer size, so every response
  // has a guaranteed slot and memory never has to be stalled.
  always_comb begin
    occupancy_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
    credit_s    = run_r && (occupancy_s < CREDIT_LIMIT);
    accept_s    = credit_s && imem_req_ready;
    rsp_fire_s  = imem_rsp_valid && !pcq_empty_s;
    keep_rsp_s  = rsp_fire_s && (drop_r == '0) && !redirect_valid;
    d_pop_s     = !ifq_empty_s && d_ready && !redirect_valid;
    inflight_next_s = inflight_s;
    case ({accept_s, rsp_fire_s})
      2'b10:   inflight_next_s = inflight_s + CNT_ONE;
      2'b01:   inflight_next_s = inflight_s - CNT_ONE;
      default: inflight_next_s = inflight_s;
    endcase
  end

  // PC, fetch enable and squash counter. On redirect every request still
  // outstanding after this cycle (including one accepted now with the old PC)
  // belongs to the abandoned path and is counted for discard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_r      <= 1'b0;
      fetch_pc_r <= RESET_PC;
      drop_r     <= '0;
    end else begin
      run_r <= 1'b1;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc & ALIGN_MASK;
        drop_r     <= inflight_next_s;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (rsp_fire_s && (drop_r != '0)) begin
          drop_r <= drop_r - CNT_ONE;
        end
      end
    end
  end

  // PCs of outstanding requests, matched to responses in order
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_fire_s),
    .head_data (rsp_pc_s),
    .full      (pcq_full_s),
    .empty     (pcq_empty_s),
    .count     (inflight_s)
  );

  // Fetched {pc, instr} pairs waiting for decode
  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (keep_rsp_s),
    .push_data ({rsp_pc_s, imem_rsp_data}),
    .pop       (d_pop_s),
    .head_data (head_s),
    .full      (ifq_full_s),
    .empty     (ifq_empty_s),
    .count     (fifo_count_s)
  );

  fetch_unit_checker u_checker (
    .clock     (clock),
    .reset     (reset),
    .rsp_valid (imem_rsp_valid),
    .pcq_empty (pcq_empty_s),
    .pcq_push  (accept_s),
    .pcq_full  (pcq_full_s),
    .ifq_push  (keep_rsp_s),
    .ifq_pop   (d_pop_s),
    .ifq_full  (ifq_full_s)
  );

  assign imem_req_valid = credit_s;
  assign imem_req_addr  = fetch_pc_r;
  assign d_valid        = !ifq_empty_s;
  assign d_instr        = head_s[INSTR_W-1:0];
  assign d_pc           = head_s[EW-1:INSTR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable in-order memory
// model, a scoreboard of expected decode PCs (sequential words from the last
// reset/redirect target) and directed timing checks around it.
module tb_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [31:0] d_instr;
  logic [31:0] d_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int consumed = 0;
  int lat_min = 1;
  int lat_max = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];

  fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_instr        (d_instr),
    .d_pc           (d_pc)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected decode stream: consecutive words from base, wrapping at 2^32
  task automatic start_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back(base + 32'(i * 4));
    end
  endtask

  task automatic issue_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    start_stream(target & 32'hFFFF_FFFC);
  endtask

  // In-order memory with per-request latency in [lat_min, lat_max]
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        mq.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr,
                       due: cyc + int'($urandom_range(lat_max, lat_min))});
        acc_cnt++;
      end
      @(posedge clock);
      #1;
      if (reset && (mq.size() > 0) && (mq[0].due <= cyc)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: every instruction decode takes is compared with the scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (reset && d_valid && d_ready && !redirect_valid) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got_pc=%h want=none", d_pc);
        end else begin
          e = exp_q.pop_front();
          check("d_pc", {32'h0, d_pc}, {32'h0, e});
          check("d_instr", {32'h0, d_instr}, {32'h0, mem_word(e)});
        end
      end
    end
  end

  initial begin
    logic [31:0] t;

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_req_valid", 64'(imem_req_valid), 64'h0);
    check("rst_d_valid", 64'(d_valid), 64'h0);
    check("rst_d_instr", 64'(d_instr), 64'h0);
    check("rst_d_pc", 64'(d_pc), 64'h0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RPC));

    // Release with decode stalled: credit must cap requests at DEPTH
    tick();
    start_stream(RPC);
    acc_cnt = 0;
    reset = 1'b1;
    @(negedge clock);
    check("cycle0_req_valid", 64'(imem_req_valid), 64'h0);
    tick();
    @(negedge clock);
    check("first_req_valid", 64'(imem_req_valid), 64'h1);
    check("first_req_addr", 64'(imem_req_addr), 64'(RPC));
    repeat (12) tick();
    check("stall_req_count", 64'(acc_cnt), 64'(DEPTH));
    @(negedge clock);
    check("stall_req_valid", 64'(imem_req_valid), 64'h0);
    check("stall_d_valid", 64'(d_valid), 64'h1);
    check("stall_head_pc", 64'(d_pc), 64'(RPC));
    tick();
    d_ready = 1'b1;
    repeat (10) tick();

    // Asynchronous reset mid-stream clears outputs without waiting for a clock
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_req_valid", 64'(imem_req_valid), 64'h0);
    check("async_d_valid", 64'(d_valid), 64'h0);
    check("async_d_instr", 64'(d_instr), 64'h0);
    check("async_d_pc", 64'(d_pc), 64'h0);
    repeat (3) tick();
    start_stream(RPC);
    reset = 1'b1;
    @(negedge clock);
    check("restart_c0_d_valid", 64'(d_valid), 64'h0);
    tick();
    @(negedge clock);
    check("restart_req_addr", 64'(imem_req_addr), 64'(RPC));
    tick();
    @(negedge clock);
    check("restart_c2_d_valid", 64'(d_valid), 64'h0);
    tick();
    @(negedge clock);
    check("restart_c3_d_valid", 64'(d_valid), 64'h1);
    check("restart_c3_d_pc", 64'(d_pc), 64'(RPC));
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clock);
      check("throughput_d_valid", 64'(d_valid), 64'h1);
    end

    // Redirect in a cycle with a response and a decode pop (1-cycle memory)
    tick();
    issue_redirect(32'h0000_0300);
    @(negedge clock);
    check("redir_pop_present", 64'(d_valid), 64'h1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redir_n1_addr", 64'(imem_req_addr), 64'h300);
    check("redir_n1_d_valid", 64'(d_valid), 64'h0);
    tick();
    @(negedge clock);
    check("redir_n2_d_valid", 64'(d_valid), 64'h0);
    tick();
    @(negedge clock);
    check("redir_n3_d_valid", 64'(d_valid), 64'h1);
    check("redir_n3_d_pc", 64'(d_pc), 64'h300);
    repeat (6) tick();

    // Unaligned redirect target is word-aligned
    issue_redirect(32'h0000_0203);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("align_req_addr", 64'(imem_req_addr), 64'h200);
    repeat (8) tick();

    // 3-cycle memory: outstanding old-path responses are squashed
    lat_min = 3;
    lat_max = 3;
    repeat (12) tick();
    issue_redirect(32'h0000_0100);
    tick();
    redirect_valid = 1'b0;
    repeat (16) tick();

    // PC wraps from the top of the address space
    lat_min = 1;
    lat_max = 1;
    issue_redirect(32'hFFFF_FFF4);
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();

    // Randomised traffic: decode stalls, memory stalls, latency, redirects
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      tick();
      redirect_valid = 1'b0;
      d_ready        = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) begin
        t = $urandom;
        issue_redirect(t);
      end
    end
    tick();
    redirect_valid = 1'b0;
    d_ready        = 1'b1;
    imem_req_ready = 1'b1;
    repeat (30) tick();
    check("consumed_enough", 64'(consumed > 600), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage replacing the fixed PC register, PC+4 adder and PC-source mux of the current core. It owns the PC and issues requests to an instruction memory with variable response latency. It supports taken-branch/jump redirects with squashing of in-flight responses, and buffers fetched instructions in a small FIFO so decode can stall without stalling memory. It sits between instruction memory and the fetch-to-decode pipeline register.

## Interface
Parameters:
- XLEN, 32, PC/address width
- RESET_PC, 32'h0000_0000, PC loaded at reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also caps outstanding requests

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- imem_req_valid  out  1  fetch request offered this cycle
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  instruction returned; in order, one per accepted request, never back-pressured
- imem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  branch/jump taken; restart fetch
- redirect_pc  in  XLEN  new PC; bits [1:0] forced to 0
- d_valid  out  1  instruction available to decode
- d_ready  in  1  decode consumes this cycle
- d_instr  out  32  instruction at FIFO head
- d_pc  out  XLEN  PC of d_instr

## Operation
- State: fetch_pc, in-flight PC queue (FIFO_DEPTH entries), inflight count, drop count, instruction FIFO of {pc, instr}.
- Credit: imem_req_valid = 1 iff fifo_count + inflight < FIFO_DEPTH; not gated by redirect_valid.
- Request accept (valid & ready): push fetch_pc into PC queue, inflight+1, fetch_pc += 4 (mod 2^XLEN, wraps silently).
- Response: pop PC queue, inflight−1. If drop > 0 or redirect_valid this cycle: discard, drop−1 (if >0). Else push {pc, imem_rsp_data} into FIFO.
- Pop: d_valid & d_ready removes FIFO head.
- Redirect: fetch_pc ← redirect_pc & ~3; FIFO flushed; drop ← inflight after this cycle's accept/response updates. A request accepted in the redirect cycle carries the old PC and is dropped; a response in the redirect cycle is discarded; decode pop in the redirect cycle is ignored (FIFO flushed regardless).
- Push and pop in the same cycle with FIFO full is legal; credit guarantees push never overflows.
- Response with inflight = 0 is a protocol error: ignored, assertion fires.

## Timing
- Reset (async assert): fetch_pc = RESET_PC, inflight = drop = 0, FIFO empty, imem_req_valid = 0, d_valid = 0, d_instr = 0, d_pc = 0. Reset mid-operation discards everything; late responses after release are a memory-side error.
- First request: first rising edge after reset release (imem_req_valid = 1, addr = RESET_PC).
- FIFO output registered, no bypass: response at cycle N → d_valid at N+1.
- Redirect at N → imem_req_addr = redirect_pc at N+1; with 1-cycle memory, d_valid at N+3.
- Sustained throughput: 1 instr/cycle with 1-cycle memory and d_ready held high, FIFO_DEPTH ≥ 2.
- d_instr/d_pc stable while d_valid & !d_ready, absent redirect.

## Structure
- RESET_PC default and NOP encoding go in the shared parameters.v include.
- One sub-module: fetch_fifo (synchronous FIFO, parametrised width/depth, flush input, full/empty/count), instantiated for the instruction FIFO and the in-flight PC queue.
- Credit, drop counter and PC logic live in fetch_unit.

## Test plan
- Reset release, 1-cycle memory returning addr-derived words, d_ready=1 → d_pc = 0,4,8,… one per cycle from cycle 3, d_instr matches.
- d_ready=0 for 10 cycles, FIFO_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; d_ready=1 → order 0,4,8,12 preserved, no loss.
- 3-cycle memory latency, 2 in flight, redirect_pc=0x100 → both old responses discarded; next d_pc = 0x100.
- Redirect same cycle as a response and a decode pop → none of them visible; first d_pc = redirect target.
- redirect_pc=0x203 → imem_req_addr = 0x200.
- fetch_pc = 0xFFFF_FFFC → next request 0x0000_0000; async reset asserted mid-stream → all outputs zero immediately, restart at RESET_PC.
